// File: rtl/module_codificador_tx.sv
// Hamming(7,4) encoder with optional single-bit error injection and a framed
// serial transmitter (start 0, codeword LSB first, stop 1).
module module_codificador_tx #(
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] datos_entrada,
  input  logic [2:0] pos_error,
  input  logic       inicio,
  output logic       listo,
  output logic       ocupado,
  output logic [6:0] palabra_codificada,
  output logic       palabra_valida,
  output logic       tx_serial
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  typedef enum logic [1:0] {REPOSO, INICIO_BIT, DATOS, PARADA} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cycle_cnt, cycle_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [2:0]    bit_inc;
  logic [6:0]    word, word_next;
  logic          valid, valid_next;
  logic          tx, tx_next;
  logic [6:0]    codeword, error_mask;
  logic          slot_end;

  // Layout [i3,i2,i1,c2,i0,c1,c0] puts each bit at Hamming position index+1.
  always_comb begin
    codeword = {datos_entrada[3], datos_entrada[2], datos_entrada[1],
                datos_entrada[1] ^ datos_entrada[2] ^ datos_entrada[3],
                datos_entrada[0],
                datos_entrada[0] ^ datos_entrada[2] ^ datos_entrada[3],
                datos_entrada[0] ^ datos_entrada[1] ^ datos_entrada[3]};
    error_mask = '0;
    if (pos_error != 3'd0)
      error_mask = 7'(1) << (pos_error - 3'd1);
  end

  assign slot_end = (cycle_cnt == CW'(BIT_CYCLES - 1));
  assign bit_inc  = bit_idx + 3'd1;

  always_comb begin
    state_next     = state;
    cycle_cnt_next = slot_end ? '0 : cycle_cnt + 1'b1;
    bit_idx_next   = bit_idx;
    word_next      = word;
    valid_next     = 1'b0;
    tx_next        = tx;
    unique case (state)
      REPOSO: begin
        cycle_cnt_next = '0;
        tx_next        = 1'b1;
        if (inicio) begin
          state_next   = INICIO_BIT;
          bit_idx_next = 3'd0;
          word_next    = codeword ^ error_mask;
          valid_next   = 1'b1;
          tx_next      = 1'b0;
        end
      end
      INICIO_BIT: begin
        if (slot_end) begin
          state_next   = DATOS;
          bit_idx_next = 3'd0;
          tx_next      = word[0];
        end
      end
      DATOS: begin
        if (slot_end) begin
          if (bit_idx == 3'd6) begin
            state_next = PARADA;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_inc;
            tx_next      = word[bit_inc];
          end
        end
      end
      PARADA: begin
        if (slot_end) begin
          state_next = REPOSO;
          tx_next    = 1'b1;
        end
      end
      default: state_next = REPOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REPOSO;
      cycle_cnt <= '0;
      bit_idx   <= 3'd0;
      word      <= 7'd0;
      valid     <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state     <= state_next;
      cycle_cnt <= cycle_cnt_next;
      bit_idx   <= bit_idx_next;
      word      <= word_next;
      valid     <= valid_next;
      tx        <= tx_next;
    end
  end

  assign listo              = (state == REPOSO);
  assign ocupado            = ~listo;
  assign palabra_codificada = word;
  assign palabra_valida     = valid;
  assign tx_serial          = tx;

endmodule

// File: tb/tb_module_codificador_tx.sv
// Bench for module_codificador_tx: two instances (BIT_CYCLES 4 and 1), a
// scoreboard on palabra_valida, and per-frame serial line reconstruction.
module tb_module_codificador_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] datos = '0;
  logic [2:0] pos = '0;
  logic inicio4 = 1'b0, inicio1 = 1'b0;
  logic listo4, ocup4, val4, tx4, listo1, ocup1, val1, tx1;
  logic [6:0] pal4, pal1;

  module_codificador_tx #(.BIT_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .datos_entrada(datos), .pos_error(pos), .inicio(inicio4),
    .listo(listo4), .ocupado(ocup4), .palabra_codificada(pal4),
    .palabra_valida(val4), .tx_serial(tx4));

  module_codificador_tx #(.BIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .datos_entrada(datos), .pos_error(pos), .inicio(inicio1),
    .listo(listo1), .ocupado(ocup1), .palabra_codificada(pal1),
    .palabra_valida(val1), .tx_serial(tx1));

  int checks = 0;
  int errors = 0;
  logic [6:0] q4[$], q1[$];
  logic [6:0] exp4, exp1;
  logic pv4 = 1'b0, pv1 = 1'b0;

  bit sel = 1'b0;
  logic listo_s, ocup_s, tx_s;
  logic [6:0] pal_s;
  int bc_s;
  always_comb begin
    listo_s = sel ? listo1 : listo4;
    ocup_s  = sel ? ocup1  : ocup4;
    tx_s    = sel ? tx1    : tx4;
    pal_s   = sel ? pal1   : pal4;
    bc_s    = sel ? 1 : 4;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d, input logic [2:0] pe);
    logic [6:0] w;
    int idx;
    w = {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
    if (pe != 0) begin
      idx = int'(pe) - 1;
      w[idx] = ~w[idx];
    end
    return w;
  endfunction

  function automatic logic [2:0] synd(input logic [6:0] w);
    return {w[3]^w[4]^w[5]^w[6], w[1]^w[2]^w[5]^w[6], w[0]^w[2]^w[4]^w[6]};
  endfunction

  // Scoreboard: every palabra_valida pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst) pv4 = 1'b0;
    else begin
      if (val4) begin
        if (q4.size() == 0) check("valid4_unexpected", {1'b1, pal4}, 8'h0);
        else begin
          exp4 = q4.pop_front();
          check("word4_scoreboard", pal4, exp4);
        end
        check("valid4_single_cycle", pv4, 0);
      end
      pv4 = val4;
    end
  end

  always @(negedge clk) begin
    if (rst) pv1 = 1'b0;
    else begin
      if (val1) begin
        if (q1.size() == 0) check("valid1_unexpected", {1'b1, pal1}, 8'h0);
        else begin
          exp1 = q1.pop_front();
          check("word1_scoreboard", pal1, exp1);
        end
        check("valid1_single_cycle", pv1, 0);
      end
      pv1 = val1;
    end
  end

  // Returns at the negedge of cycle 1 (after the accept edge).
  task automatic start(input bit s, input logic [3:0] d, input logic [2:0] pe, input logic [6:0] e);
    int n = 0;
    sel = s;
    @(negedge clk);
    while (!listo_s && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!listo_s) check("listo_timeout", 0, 1);
    datos = d;
    pos = pe;
    if (s) inicio1 = 1'b1; else inicio4 = 1'b1;
    @(posedge clk);
    if (s) q1.push_back(e); else q4.push_back(e);
    @(negedge clk);
    inicio1 = 1'b0;
    inicio4 = 1'b0;
  endtask

  // Samples cycles 1..9*BC from the current negedge, then the first idle cycle.
  task automatic check_frame(input string name, input logic [6:0] w);
    logic [35:0] got, req;
    bit busy_ok = 1'b1;
    int bc = bc_s;
    int n = 9 * bc;
    int slot;
    got = '0;
    req = '0;
    for (int i = 0; i < n; i++) begin
      slot = i / bc;
      req[i] = (slot == 0) ? 1'b0 : (slot == 8) ? 1'b1 : w[slot-1];
      got[i] = tx_s;
      if (listo_s || !ocup_s) busy_ok = 1'b0;
      if (i < n - 1) @(negedge clk);
    end
    check({name, "_serial"}, got, req);
    check({name, "_busy"}, busy_ok, 1);
    @(negedge clk);
    check({name, "_idle"}, {listo_s, ocup_s, tx_s}, 3'b101);
  endtask

  typedef struct {
    logic [3:0] d;
    logic [2:0] pe;
    logic [6:0] w;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [6:0] e;
    bit idle_ok;
    vecs[0] = '{4'b1011, 3'd0, 7'h55};
    vecs[1] = '{4'b1011, 3'd3, 7'h51};
    vecs[2] = '{4'b0000, 3'd0, 7'h00};
    vecs[3] = '{4'b1111, 3'd0, 7'h7F};
    vecs[4] = '{4'b0001, 3'd0, 7'h07};
    vecs[5] = '{4'b1011, 3'd7, 7'h15};
    vecs[6] = '{4'b0000, 3'd1, 7'h01};
    vecs[7] = '{4'b1111, 3'd4, 7'h77};

    repeat (3) @(negedge clk);
    check("reset_state4", {listo4, ocup4, pal4, val4, tx4}, {2'b10, 7'h00, 2'b01});
    check("reset_state1", {listo1, ocup1, pal1, val1, tx1}, {2'b10, 7'h00, 2'b01});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start(0, vecs[i].d, vecs[i].pe, vecs[i].w);
      check_frame($sformatf("vec%0d", i), vecs[i].w);
      check($sformatf("vec%0d_word", i), pal4, vecs[i].w);
      check($sformatf("vec%0d_syndrome", i), synd(pal4), vecs[i].pe);
    end

    // Mid-frame input changes and inicio pulses must be ignored.
    start(0, 4'b1011, 3'd0, 7'h55);
    fork
      check_frame("busy", 7'h55);
      begin
        repeat (10) @(negedge clk);
        datos = 4'b0110;
        pos = 3'd5;
        inicio4 = 1'b1;
        repeat (3) @(negedge clk);
        inicio4 = 1'b0;
      end
    join
    check("busy_word_held", pal4, 7'h55);

    // inicio held high: exactly one idle cycle between frames.
    sel = 1'b0;
    datos = 4'b1011;
    pos = 3'd0;
    inicio4 = 1'b1;
    @(posedge clk);
    q4.push_back(7'h55);
    @(negedge clk);
    check_frame("held1", 7'h55);
    datos = 4'b0001;
    q4.push_back(7'h07);
    @(negedge clk);
    inicio4 = 1'b0;
    check("held2_started", {listo4, ocup4, tx4}, 3'b010);
    check("held2_word", pal4, 7'h07);
    repeat (9 * 4) @(negedge clk);
    check("held2_done", {listo4, tx4}, 2'b11);

    // Asynchronous reset in the middle of a frame.
    start(0, 4'b1011, 3'd0, 7'h55);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_midframe", {listo4, ocup4, pal4, tx4}, {2'b10, 7'h00, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    idle_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (!tx4 || !listo4) idle_ok = 1'b0;
    end
    check("post_reset_idle", idle_ok, 1);

    // BIT_CYCLES=1: full sweep, syndrome must equal pos_error.
    start(1, 4'b1011, 3'd0, 7'h55);
    check_frame("bc1_55", 7'h55);
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        e = enc(4'(d), 3'(p));
        start(1, 4'(d), 3'(p), e);
        check_frame($sformatf("sweep_d%0d_p%0d", d, p), e);
        check($sformatf("sweep_d%0d_p%0d_syndrome", d, p), synd(pal1), p);
        if (p == 0)
          check($sformatf("sweep_d%0d_data", d), {pal1[6], pal1[5], pal1[4], pal1[2]}, d);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", q4.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/module_codificador_tx.md
# module_codificador_tx

Hamming(7,4) encoder and serial transmitter. The block accepts a 4-bit data nibble on a start request and builds the 7-bit codeword in the codeword layout `[i3,i2,i1,c2,i0,c1,c0]`. It can optionally flip one codeword bit to emulate a channel error. It registers the resulting word and sends it as a framed serial stream. It is the transmit end of the error-detection path: the syndrome of any word it emits equals `pos_error`.

## Interface

Parameters:
- `BIT_CYCLES`, default 4: clock cycles each serial bit slot is held. Legal range is ≥1.

Ports:
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `datos_entrada` input, 4 bits: data nibble `[i3,i2,i1,i0]`.
- `pos_error` input, 3 bits: error injection control. 0 means no error; 1–7 flips codeword bit `pos_error-1`.
- `inicio` input, 1 bit: start request. It is sampled only while `listo`=1.
- `listo` output, 1 bit: idle and able to accept `inicio`.
- `ocupado` output, 1 bit: frame in progress. Always equals `~listo`.
- `palabra_codificada` output, 7 bits: registered transmitted codeword, with error applied.
- `palabra_valida` output, 1 bit: one-cycle pulse when `palabra_codificada` updates.
- `tx_serial` output, 1 bit: serial line. Idles high.

## Operation

Encoding (combinational from `datos_entrada`, captured on accept):
- c0 = i0^i1^i3
- c1 = i0^i2^i3
- c2 = i1^i2^i3
- Word bit layout: bit6..0 = i3,i2,i1,c2,i0,c1,c0.
- If `pos_error`≠0, bit[`pos_error`-1] is XOR-inverted. Only one bit ever flips.

Frame:
- Start bit 0, then codeword bits 0..6 (LSB first), then stop bit 1.
- 9 slots in total, each held exactly `BIT_CYCLES` cycles.

FSM states and transitions:
- REPOSO → INICIO_BIT when `inicio`=1.
  - On that edge, `datos_entrada` and `pos_error` are captured and `palabra_codificada` is loaded.
  - The bit counter and the cycle counter are cleared.
- INICIO_BIT → DATOS after `BIT_CYCLES` cycles.
- DATOS stays for 7 slots (bit index 0..6), then → PARADA.
  - The cycle counter wraps at `BIT_CYCLES`-1; the bit index increments on each wrap.
- PARADA → REPOSO after `BIT_CYCLES` cycles.

Rules:
- `inicio` is ignored outside REPOSO. Input changes mid-frame have no effect; only the captured values are sent.
- `palabra_codificada` holds its value until the next accept.
- `inicio` held high continuously restarts a new frame in the first REPOSO cycle. Back-to-back frames therefore have exactly 1 idle cycle (`tx_serial`=1, `listo`=1) between them.

## Timing

Reset values (asynchronous, immediate, including mid-frame):
- State REPOSO
- `listo`=1, `ocupado`=0
- `palabra_codificada`=7'b0000000
- `palabra_valida`=0
- `tx_serial`=1
- All counters 0

After reset release, the first `inicio` is accepted on the first rising edge at which it is high.

Cycle numbering is relative to the accept edge, E0:
- `palabra_codificada` is valid and `palabra_valida`=1 in cycle 1 only.
- `listo` falls in cycle 1.
- `tx_serial` is driven from a register, so it has no glitches:
  - 0 for cycles 1..`BIT_CYCLES`
  - bit k for cycles (k+1)·`BIT_CYCLES`+1 .. (k+2)·`BIT_CYCLES`
  - 1 (stop) for cycles 8·`BIT_CYCLES`+1 .. 9·`BIT_CYCLES`
- `listo` rises in cycle 9·`BIT_CYCLES`+1.
- Total busy time is 9·`BIT_CYCLES` cycles.

## Test plan

- Reset: assert `rst` mid-frame with `BIT_CYCLES`=4 → same cycle `tx_serial`=1, `listo`=1, `palabra_codificada`=0. After release, nothing transmits until `inicio`.
- Clean encode: `datos_entrada`=4'b1011, `pos_error`=0, pulse `inicio`:
  - `palabra_codificada`=7'h55 with `palabra_valida` high for 1 cycle.
  - Serial line shows 0, then 1,0,1,0,1,0,1, then 1, each slot 4 cycles; 36 busy cycles in total.
- Error injection: `datos_entrada`=4'b1011, `pos_error`=3 → `palabra_codificada`=7'h51. A reference syndrome computed on the output equals 3.
- Sweep: all 16 nibbles × all 8 `pos_error` values. Syndrome of each output equals `pos_error`, and the data bits match the input when `pos_error`=0. Spot checks: 4'b0000→7'h00, 4'b1111→7'h7F, 4'b0001→7'h07.
- Busy handling: change `datos_entrada` and pulse `inicio` mid-frame → no effect on the frame or on `palabra_codificada`. Holding `inicio` high gives consecutive frames separated by exactly one idle-high cycle.
- `BIT_CYCLES`=1: frame is 9 cycles, and the bit pattern matches the 7'h55 case.
